inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Decoupled fetch front end for the out-of-order core; successor to the single-slot fetch/decode buffering in the issue path.
- Owns the fetch PC and requests instructions from memory_unit; handles RVC step (2/4) and buffers up to DEPTH fetched instructions, each with its PC, for the decode/issue stage.
- Handles ROB clear, decode-stage predicted redirects and JALR stall/resume.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- RESET_PC, 32'h0, PC loaded on reset.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  pause when low.
- clear_in  input  1  ROB misprediction flush.
- clear_pc_in  input  32  restart PC on clear.
- redir_in  input  1  decode-stage redirect (JAL, or branch predicted taken).
- redir_pc_in  input  32  redirect target.
- stall_req_in  input  1  JALR decoded; stop fetching.
- stall_end_in  input  1  JALR target resolved.
- jalr_addr_in  input  32  JALR target.
- inst_ready_in  input  1  inst_in valid for current pc_out.
- inst_in  input  32  fetched instruction; upper half don't-care if RVC.
- mem_busy_in  input  1  memory_unit busy.
- inst_req_out  output  1  fetch request for pc_out.
- pc_out  output  32  current fetch PC.
- deq_valid_out  output  1  head entry valid.
- deq_ready_in  input  1  consumer takes head this cycle.
- deq_inst_out  output  32  head instruction.
- deq_pc_out  output  32  head PC.
- deq_is_c_out  output  1  head is compressed (inst[1:0] != 2'b11).
- count_out  output  CNT_W  occupancy.
- full_out  output  1  count == DEPTH.
- stall_out  output  1  in STALL state.

Behaviour:
- State machine: FETCH, STALL.
- Reset (async, rst_n_in low) returns: state FETCH, pc RESET_PC, rd/wr pointers 0, count 0, full_out 0, deq_valid_out 0, stall_out 0, cur_mem_busy 0.
- inst_req_out = (state == FETCH) && !full_out && !cur_mem_busy, where cur_mem_busy is mem_busy_in registered one cycle.
- Enqueue happens when inst_req_out && inst_ready_in && rdy_in. It writes {inst_in, pc, is_c} at wr_ptr and advances pc by 2 (RVC) or 4, modulo 2^32.
- Full blocks enqueue even if a dequeue happens in the same cycle.
- Dequeue happens when deq_valid_out && deq_ready_in && rdy_in. The head advances; data outputs come combinationally from the head entry, zero latency.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- An entry becomes visible at deq the cycle after it is written; there is no bypass.
- Priority per cycle:
  - clear_in: flush all, pc <= clear_pc_in, state FETCH. No enqueue or dequeue takes effect.
  - redir_in: flush all, pc <= redir_pc_in, state FETCH. A simultaneous dequeue is still honoured before the flush; the consumer owns the redirecting instruction.
  - stall_req_in: state STALL. The entry in flight this cycle is discarded; the queue is flushed after any same-cycle dequeue.
  - STALL && stall_end_in: pc <= jalr_addr_in, state FETCH; fetch resumes next cycle.
  - Otherwise, normal enqueue/dequeue.
- STALL entered while stall_end_in is already high: stall_end_in is ignored that cycle, and the resume is taken the next cycle it is asserted.
- In STALL, stall_end_in is accepted only if clear_in is low; clear overrides it.
- rdy_in low freezes all state and gates inst_req_out to 0. clear_in is still honoured while rdy_in is low.
- Reset asserted mid-operation discards all entries immediately; no output glitch is required beyond returning to reset values.

Test Plan:
- Reset, memory returns 4 RV32I instructions back to back from RESET_PC=0 -> entries at PCs 0, 4, 8, 12 dequeue in order, deq_is_c_out=0, count_out peaks at 1 with deq_ready_in=1.
- Mixed stream RVC, RV32I, RVC with deq_ready_in=0 -> deq PCs 0x0, 0x2, 0x6; pc_out=0x8; count_out=3.
- deq_ready_in=0 for DEPTH+2 fetch cycles -> full_out=1 at count 8, inst_req_out=0, pc_out frozen. Then one dequeue -> count 7, fetch resumes at the next PC.
- Queue holds 5 entries; clear_in with clear_pc_in=0x100 together with deq_ready_in=1 -> count 0, no dequeue counted, next inst_req_out at pc_out 0x100.
- stall_req_in at count 3 -> stall_out=1, queue empty, inst_req_out=0. stall_end_in=1 with jalr_addr_in=0x2A4 three cycles later -> pc_out=0x2A4, stall_out=0.
- rdy_in=0 for 4 cycles during streaming -> count/pc/pointers unchanged, inst_req_out=0. Then rst_n_in pulsed low asynchronously mid-cycle -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupled fetch front end with RVC-aware PC step and DEPTH-entry instruction queue
module inst_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic [31:0]      clear_pc_in,
  input  logic             redir_in,
  input  logic [31:0]      redir_pc_in,
  input  logic             stall_req_in,
  input  logic             stall_end_in,
  input  logic [31:0]      jalr_addr_in,
  input  logic             inst_ready_in,
  input  logic [31:0]      inst_in,
  input  logic             mem_busy_in,
  output logic             inst_req_out,
  output logic [31:0]      pc_out,
  output logic             deq_valid_out,
  input  logic             deq_ready_in,
  output logic [31:0]      deq_inst_out,
  output logic [31:0]      deq_pc_out,
  output logic             deq_is_c_out,
  output logic [CNT_W-1:0] count_out,
  output logic             full_out,
  output logic             stall_out
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {FETCH = 1'b0, STALL = 1'b1} state_t;

  state_t           state, state_next;
  logic             cur_mem_busy;
  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [DEPTH-1:0] c_mem;

  logic        full, enq, deq, flush, resume, new_is_c;
  logic [31:0] pc_step;

  assign full     = (count == CNT_W'(DEPTH));
  assign new_is_c = (inst_in[1:0] != 2'b11);
  assign pc_step  = new_is_c ? 32'd2 : 32'd4;
  assign enq      = inst_req_out && inst_ready_in;
  assign deq      = (count != '0) && deq_ready_in && rdy_in;
  // clear wins even while paused; redirect and stall only act when running
  assign flush    = clear_in || (rdy_in && (redir_in || stall_req_in));
  assign resume   = (state == STALL) && stall_end_in && rdy_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= FETCH;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_in)
      state_next = FETCH;
    else if (rdy_in) begin
      if (redir_in)                               state_next = FETCH;
      else if (stall_req_in)                      state_next = STALL;
      else if ((state == STALL) && stall_end_in)  state_next = FETCH;
    end
  end

  always_comb begin
    stall_out    = (state == STALL);
    inst_req_out = (state == FETCH) && !full && !cur_mem_busy && rdy_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cur_mem_busy <= 1'b0;
      pc           <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      cur_mem_busy <= mem_busy_in;
      if (flush) begin
        // any same-cycle dequeue is moot: the whole queue is dropped
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (clear_in)      pc <= clear_pc_in;
        else if (redir_in) pc <= redir_pc_in;
      end else if (resume) begin
        pc <= jalr_addr_in;
      end else begin
        if (enq) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          pc     <= pc + pc_step;
        end
        if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
        if (enq && !deq)      count <= count + CNT_W'(1);
        else if (!enq && deq) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq && !flush) begin
      inst_mem[wr_ptr] <= inst_in;
      pc_mem[wr_ptr]   <= pc;
      c_mem[wr_ptr]    <= new_is_c;
    end
  end

  assign pc_out        = pc;
  assign count_out     = count;
  assign full_out      = full;
  assign deq_valid_out = (count != '0);
  assign deq_inst_out  = inst_mem[rd_ptr];
  assign deq_pc_out    = pc_mem[rd_ptr];
  assign deq_is_c_out  = c_mem[rd_ptr];

endmodule
